// File: rtl/seg_bus_pkg.sv
// Shared definitions for the 2-wire 7-segment display bus (responder and driver).
package seg_bus_pkg;

    // Responder receive state machine.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RX_BYTE   = 2'd1,
        ACK       = 2'd2,
        WAIT_STOP = 2'd3
    } state_t;

    // Kind of frame, set by the first byte after START.
    typedef enum logic [1:0] {
        FK_NONE = 2'd0,
        FK_DATA = 2'd1,
        FK_CTRL = 2'd2,
        FK_ADDR = 2'd3
    } frame_kind_t;

    // Command encodings in cmd[7:6].
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_CTRL = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Bit of the data command that selects fixed addressing.
    localparam int FIXED_BIT = 2;

    // Next digit address after a data byte: hold in fixed mode, saturate at 7.
    function automatic logic [2:0] addr_next(input logic [2:0] addr, input logic fixed);
        if (fixed || addr == 3'd7) begin
            return addr;
        end
        return addr + 3'd1;
    endfunction

endpackage

// File: rtl/seg_bus_responder_if.sv
// Open-drain 2-wire display bus: SCL and the resolved SDA pad level, plus the
// responder's pull-low enable.
interface seg_bus_responder_if;
    logic scl;
    logic sda;
    logic sda_oe;

    modport slave  (input scl, input sda, output sda_oe);
    modport master (output scl, output sda, input sda_oe);
endinterface

// File: rtl/seg_bus_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line, with single-cycle
// rise/fall pulses derived from the synchronized level.
module seg_bus_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic porb_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;

    // Shift the raw pin into the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_i};
    end

    // Synchronizer and previous-level flops; reset to the idle (high) bus level
    // so that leaving reset does not fabricate edges on an idle bus.
    always_ff @(posedge clk_i or negedge porb_i) begin
        if (!porb_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/seg_bus_responder.sv
// Responder end of the TM1637-style 7-segment display bus. Decodes START/STOP
// and LSB-first bytes, ACKs valid bytes, executes data/address/control
// commands and presents the committed digit registers and display settings.
module seg_bus_responder #(
    parameter int NUM_DIGITS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk_i,
    input  logic                         porb_i,
    seg_bus_responder_if.slave           bus,
    output logic [NUM_DIGITS-1:0][7:0]   digits_o,
    output logic                         display_on_o,
    output logic [2:0]                   brightness_o,
    output logic                         frame_done_o,
    output logic                         proto_err_o,
    output logic                         busy_o
);
    import seg_bus_pkg::*;

    logic scl_lvl;
    logic scl_rise;
    logic scl_fall;
    logic sda_lvl;
    logic sda_rise;
    logic sda_fall;

    seg_bus_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk_i   (clk_i),
        .porb_i  (porb_i),
        .async_i (bus.scl),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    seg_bus_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk_i   (clk_i),
        .porb_i  (porb_i),
        .async_i (bus.sda),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    // Both lines share the same synchronizer depth, so the SCL level is aligned
    // with the SDA edge it qualifies.
    logic start_w;
    logic stop_w;
    assign start_w = sda_fall & scl_lvl;
    assign stop_w  = sda_rise & scl_lvl;

    state_t                    state_q;
    frame_kind_t               kind_q;
    logic [2:0]                bit_cnt_q;
    logic [6:0]                shreg_q;
    logic [2:0]                addr_q;
    logic                      mode_fixed_q;
    logic                      first_q;
    logic                      data_seen_q;
    logic                      ack_half_q;
    logic                      sda_oe_q;
    logic                      ctrl_pend_q;
    logic [3:0]                ctrl_q;
    logic                      ctrl_go_q;
    logic                      commit_q;
    logic                      proto_err_q;
    logic [NUM_DIGITS-1:0][7:0] shadow_q;
    logic [NUM_DIGITS-1:0][7:0] digits_q;
    logic                      display_on_q;
    logic [2:0]                brightness_q;
    logic                      frame_done_q;

    // Completed byte on the 8th SCL rise: the bit on SDA now is the MSB.
    logic [7:0] byte_w;
    assign byte_w = {sda_lvl, shreg_q};

    // Receive FSM: framing, bit shifting, command decode, shadow writes, ACK drive.
    // A STOP or repeated START always follows an SCL rise that has already
    // bumped bit_cnt_q, so a partial byte is only present when bit_cnt_q > 1.
    always_ff @(posedge clk_i or negedge porb_i) begin
        if (!porb_i) begin
            state_q      <= IDLE;
            kind_q       <= FK_NONE;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 7'd0;
            addr_q       <= 3'd0;
            mode_fixed_q <= 1'b0;
            first_q      <= 1'b0;
            data_seen_q  <= 1'b0;
            ack_half_q   <= 1'b0;
            sda_oe_q     <= 1'b0;
            ctrl_pend_q  <= 1'b0;
            ctrl_q       <= 4'd0;
            ctrl_go_q    <= 1'b0;
            commit_q     <= 1'b0;
            proto_err_q  <= 1'b0;
            shadow_q     <= '0;
        end else begin
            proto_err_q <= 1'b0;
            commit_q    <= 1'b0;
            ctrl_go_q   <= 1'b0;
            if (start_w) begin
                if ((state_q == RX_BYTE && bit_cnt_q > 3'd1) || state_q == ACK) begin
                    proto_err_q <= 1'b1;
                end
                state_q     <= RX_BYTE;
                kind_q      <= FK_NONE;
                bit_cnt_q   <= 3'd0;
                first_q     <= 1'b1;
                data_seen_q <= 1'b0;
                ack_half_q  <= 1'b0;
                sda_oe_q    <= 1'b0;
                ctrl_pend_q <= 1'b0;
            end else if (stop_w) begin
                if (state_q == RX_BYTE && bit_cnt_q > 3'd1) begin
                    proto_err_q <= 1'b1;
                end else if ((state_q == RX_BYTE || state_q == ACK) &&
                             kind_q == FK_ADDR && data_seen_q) begin
                    commit_q <= 1'b1;
                end
                state_q     <= IDLE;
                bit_cnt_q   <= 3'd0;
                ack_half_q  <= 1'b0;
                sda_oe_q    <= 1'b0;
                ctrl_pend_q <= 1'b0;
            end else begin
                case (state_q)
                    RX_BYTE: begin
                        if (scl_rise) begin
                            shreg_q   <= byte_w[7:1];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (first_q) begin
                                    first_q <= 1'b0;
                                    case (byte_w[7:6])
                                        CMD_DATA: begin
                                            mode_fixed_q <= byte_w[FIXED_BIT];
                                            kind_q       <= FK_DATA;
                                            state_q      <= ACK;
                                        end
                                        CMD_ADDR: begin
                                            addr_q  <= byte_w[2:0];
                                            kind_q  <= FK_ADDR;
                                            state_q <= ACK;
                                        end
                                        CMD_CTRL: begin
                                            ctrl_q      <= byte_w[3:0];
                                            ctrl_pend_q <= 1'b1;
                                            kind_q      <= FK_CTRL;
                                            state_q     <= ACK;
                                        end
                                        default: begin
                                            proto_err_q <= 1'b1;
                                            state_q     <= WAIT_STOP;
                                        end
                                    endcase
                                end else if (kind_q == FK_ADDR) begin
                                    // Addresses beyond the implemented digits are ACKed and dropped.
                                    for (int i = 0; i < NUM_DIGITS; i++) begin
                                        if (addr_q == 3'(i)) begin
                                            shadow_q[i] <= byte_w;
                                        end
                                    end
                                    addr_q      <= addr_next(addr_q, mode_fixed_q);
                                    data_seen_q <= 1'b1;
                                    state_q     <= ACK;
                                end else begin
                                    proto_err_q <= 1'b1;
                                    state_q     <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    ACK: begin
                        if (scl_fall) begin
                            if (!ack_half_q) begin
                                sda_oe_q    <= 1'b1;
                                ack_half_q  <= 1'b1;
                                ctrl_go_q   <= ctrl_pend_q;
                                ctrl_pend_q <= 1'b0;
                            end else begin
                                sda_oe_q   <= 1'b0;
                                ack_half_q <= 1'b0;
                                state_q    <= RX_BYTE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Visible outputs: digit commit after STOP and control update after ACK start.
    always_ff @(posedge clk_i or negedge porb_i) begin
        if (!porb_i) begin
            digits_q     <= '0;
            display_on_q <= 1'b0;
            brightness_q <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= commit_q;
            if (commit_q) begin
                digits_q <= shadow_q;
            end
            if (ctrl_go_q) begin
                display_on_q <= ctrl_q[3];
                brightness_q <= ctrl_q[2:0];
            end
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign digits_o     = digits_q;
    assign display_on_o = display_on_q;
    assign brightness_o = brightness_q;
    assign frame_done_o = frame_done_q;
    assign proto_err_o  = proto_err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_seg_bus_responder.sv
// Bench for seg_bus_responder: bus initiator with open-drain pull-up model,
// table of whole frames plus hand-written abort / repeated-start / reset cases.
module tb_seg_bus_responder;
    import seg_bus_pkg::*;

    localparam int CLK_DIV = 100;
    localparam int Q       = CLK_DIV / 4;

    logic clk  = 1'b0;
    logic porb = 1'b0;
    always #5 clk = ~clk;

    seg_bus_responder_if bus();
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;
    assign bus.scl = scl_drv;
    assign bus.sda = sda_drv & ~bus.sda_oe;

    logic [3:0][7:0] digits;
    logic            display_on;
    logic [2:0]      brightness;
    logic            frame_done;
    logic            proto_err;
    logic            busy;

    seg_bus_responder #(.NUM_DIGITS(4), .SYNC_STAGES(2)) dut (
        .clk_i        (clk),
        .porb_i       (porb),
        .bus          (bus),
        .digits_o     (digits),
        .display_on_o (display_on),
        .brightness_o (brightness),
        .frame_done_o (frame_done),
        .proto_err_o  (proto_err),
        .busy_o       (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboards: expected ACKs and committed digit snapshots.
    logic        ack_exp_q[$];
    logic [31:0] dig_exp_q[$];
    logic [31:0] obs_q[$];
    int          obs_rd = 0;
    int          pe_cnt = 0;

    // Model of the committed outputs.
    logic [31:0] m_dig = 32'h0;
    logic        m_on  = 1'b0;
    logic [2:0]  m_br  = 3'd0;

    always @(negedge clk) begin
        if (porb) begin
            if (frame_done) obs_q.push_back(digits);
            if (proto_err) pe_cnt++;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic rep_start();
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_drv = b[i]; wait_q();
            scl_drv = 1'b1; wait_q();
            wait_q();
            scl_drv = 1'b0; wait_q();
        end
    endtask

    task automatic ack_clock();
        logic got;
        logic exp;
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        @(negedge clk);
        got = ~bus.sda;
        exp = ack_exp_q.pop_front();
        check("ack", got, exp);
        wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        ack_exp_q.push_back(exp_ack);
        send_bits(b, 8);
        ack_clock();
    endtask

    task automatic settle_and_check(input string tag, input int pe_start, input int pe_exp);
        logic [31:0] e;
        repeat (10) @(posedge clk);
        @(negedge clk);
        while (dig_exp_q.size() > 0) begin
            e = dig_exp_q.pop_front();
            check({tag, "_frame_done_seen"}, 32'(obs_q.size() > obs_rd), 32'd1);
            if (obs_q.size() > obs_rd) begin
                check({tag, "_frame_done_digits"}, obs_q[obs_rd], e);
                obs_rd++;
            end
        end
        check({tag, "_frame_done_count"}, obs_q.size(), obs_rd);
        check({tag, "_digits"}, digits, m_dig);
        check({tag, "_display_on"}, display_on, m_on);
        check({tag, "_brightness"}, brightness, m_br);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_proto_err_pulses"}, pe_cnt - pe_start, pe_exp);
    endtask

    typedef struct {
        int              n;
        logic [0:5][7:0] b;
        logic [0:5]      ack;
        logic            commit;
        logic [31:0]     dig;
        logic            on;
        logic [2:0]      br;
        int              perr;
    } vec_t;

    vec_t vecs[13];

    task automatic run_frame(input vec_t v, input string tag);
        int pe0;
        pe0 = pe_cnt;
        if (v.commit) dig_exp_q.push_back(v.dig);
        m_dig = v.dig;
        m_on  = v.on;
        m_br  = v.br;
        bus_start();
        for (int i = 0; i < v.n; i++) send_byte(v.b[i], v.ack[i]);
        bus_stop();
        settle_and_check(tag, pe0, v.perr);
    endtask

    initial begin
        int pe0;
        vecs[0]  = '{1, {8'h40, 40'h0},                        6'b100000, 1'b0, 32'h00000000, 1'b0, 3'd0, 0};
        vecs[1]  = '{5, {8'hC0, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h00}, 6'b111110, 1'b1, 32'h4F5B063F, 1'b0, 3'd0, 0};
        vecs[2]  = '{1, {8'h8F, 40'h0},                        6'b100000, 1'b0, 32'h4F5B063F, 1'b1, 3'd7, 0};
        vecs[3]  = '{1, {8'h44, 40'h0},                        6'b100000, 1'b0, 32'h4F5B063F, 1'b1, 3'd7, 0};
        vecs[4]  = '{3, {8'hC2, 8'h66, 8'h6D, 24'h0},          6'b111000, 1'b1, 32'h4F6D063F, 1'b1, 3'd7, 0};
        vecs[5]  = '{1, {8'h40, 40'h0},                        6'b100000, 1'b0, 32'h4F6D063F, 1'b1, 3'd7, 0};
        vecs[6]  = '{4, {8'hC3, 8'h11, 8'h22, 8'h33, 16'h0},   6'b111100, 1'b1, 32'h116D063F, 1'b1, 3'd7, 0};
        vecs[7]  = '{2, {8'h00, 8'h55, 32'h0},                 6'b000000, 1'b0, 32'h116D063F, 1'b1, 3'd7, 1};
        vecs[8]  = '{1, {8'h8A, 40'h0},                        6'b100000, 1'b0, 32'h116D063F, 1'b1, 3'd2, 0};
        vecs[9]  = '{2, {8'h40, 8'h12, 32'h0},                 6'b100000, 1'b0, 32'h116D063F, 1'b1, 3'd2, 1};
        vecs[10] = '{3, {8'hC1, 8'hAA, 8'hBB, 24'h0},          6'b111000, 1'b1, 32'h11BBAA3F, 1'b1, 3'd2, 0};
        vecs[11] = '{3, {8'hC7, 8'hAA, 8'hBB, 24'h0},          6'b111000, 1'b1, 32'h11BBAA3F, 1'b1, 3'd2, 0};
        vecs[12] = '{1, {8'h87, 40'h0},                        6'b100000, 1'b0, 32'h11BBAA3F, 1'b0, 3'd7, 0};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_digits", digits, 32'h0);
        check("rst_sda_oe", bus.sda_oe, 1'b0);
        check("rst_display_on", display_on, 1'b0);
        check("rst_brightness", brightness, 3'd0);
        check("rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        porb = 1'b1;
        repeat (5) @(posedge clk);

        for (int k = 0; k < 13; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

        // STOP after 5 bits of a data byte.
        pe0 = pe_cnt;
        bus_start();
        send_byte(8'hC0, 1'b1);
        send_bits(8'h77, 5);
        bus_stop();
        settle_and_check("abort_stop", pe0, 1);

        // Repeated START after 5 bits, then a good frame.
        pe0 = pe_cnt;
        bus_start();
        send_byte(8'hC0, 1'b1);
        send_bits(8'h77, 5);
        rep_start();
        send_byte(8'hC0, 1'b1);
        send_byte(8'h77, 1'b1);
        m_dig = 32'h11BBAA77;
        dig_exp_q.push_back(m_dig);
        bus_stop();
        settle_and_check("abort_rstart", pe0, 1);

        // Reset asserted during the ACK of byte 2.
        bus_start();
        send_byte(8'hC0, 1'b1);
        send_bits(8'h01, 8);
        sda_drv = 1'b1;
        for (int k = 0; k < 4 * Q && !bus.sda_oe; k++) @(negedge clk);
        @(negedge clk);
        check("mid_ack_sda_oe", bus.sda_oe, 1'b1);
        porb = 1'b0;
        #1;
        check("rst_ack_sda_oe", bus.sda_oe, 1'b0);
        check("rst_ack_digits", digits, 32'h0);
        check("rst_ack_display_on", display_on, 1'b0);
        check("rst_ack_brightness", brightness, 3'd0);
        check("rst_ack_busy", busy, 1'b0);
        check("rst_ack_frame_done", frame_done, 1'b0);
        check("rst_ack_proto_err", proto_err, 1'b0);
        scl_drv = 1'b1;
        repeat (2) @(posedge clk);
        sda_drv = 1'b1;
        repeat (5) @(posedge clk);
        porb = 1'b1;
        repeat (5) @(posedge clk);
        m_dig = 32'h0; m_on = 1'b0; m_br = 3'd0;
        run_frame(vecs[0], "post_rst0");
        run_frame(vecs[1], "post_rst1");
        run_frame(vecs[2], "post_rst2");

        check("ack_queue_empty", ack_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
